mix_col_engine: RTL and testbench
=================================

# mix_col_engine

- Parametrised, handshaked MixColumns/InvMixColumns engine for the AES-128 datapath.
- Transforms one 128-bit state per transaction, `COLS_PER_CYCLE` columns per clock, with the direction selected per transaction.
- Sits between the ShiftRows and AddRoundKey stages of the encrypt and decrypt round loops and replaces the free-running, clock-only MixColDec.

## Interface
- `COLS_PER_CYCLE`, default 1: columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `Clk`  in  1  rising-edge clock.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `In_valid`  in  1  `In_data`/`Mode` valid.
- `In_ready`  out  1  engine can accept a state.
- `In_data`  in  128  input state. Column c is at `[127-32c -: 32]`; byte r of a column is at `[31-8r -: 8]`.
- `Mode`  in  1  0 = forward MixColumns, 1 = InvMixColumns. Sampled with `In_data`.
- `Out_valid`  out  1  `Out_data` holds a finished result.
- `Out_ready`  in  1  consumer accepts the result.
- `Out_data`  out  128  transformed state, same layout as `In_data`.
- `Busy`  out  1  high in RUN and DONE.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- **IDLE:**
  - `In_ready`=1.
  - On `In_valid && In_ready`: capture `In_data` into the state register, latch `Mode`, clear the column counter, go to RUN.
- **RUN:**
  - Each cycle, columns `cnt*N .. cnt*N+N-1` of the state register are replaced in place by their transform, where N = `COLS_PER_CYCLE`. Then `cnt` is incremented.
  - When the last group is written, go to DONE.
  - `In_ready`=0.
- **DONE:**
  - `Out_valid`=1 and `Out_data` is the state register, held stable until `Out_ready`.
  - `In_ready` = `Out_ready`, so back-to-back acceptance is allowed.
  - On `Out_ready` with no new input: go to IDLE.
  - On `Out_ready && In_valid`: capture the new state and go directly to RUN.
- **Arithmetic:**
  - Each output byte is a GF(2^8) sum (XOR) of products over the reduction polynomial 0x11B.
  - Forward matrix rows: 02 03 01 01, rotated per row.
  - Inverse matrix rows: 0E 0B 0D 09, rotated per row.
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0). All multiplications are built from xtime chains; there are no lookup tables.
- **Boundary conditions:**
  - `In_valid` while `In_ready`=0 is ignored. The source must hold it.
  - `Mode` changes during RUN have no effect.
  - `Out_ready` asserted without `Out_valid` is ignored.
- **Reset:** asserting `Rst_n` at any time aborts the transaction and discards the state. The engine returns to IDLE.
- **Reset values:**
  - `In_ready`=1.
  - `Out_valid`=0.
  - `Busy`=0.
  - `Out_data`=128'h0.
  - Counter = 0.

## Timing
- Latency: input accepted at edge k gives `Out_valid` high after edge k + 4/N. That is 4 cycles for N=1, 2 for N=2 and 1 for N=4.
- Throughput with `Out_ready` held high: one state per 4/N + 1 cycles. The DONE cycle overlaps the next acceptance.
- All outputs are registered. Combinational logic inside the block is limited to `In_ready` depending on `Out_ready` in DONE; nothing else is combinational from inputs to outputs.

## Configuration
- **`MIXCOL_INV_EN` defined:** the inverse datapath is compiled in and `Mode` selects the direction per transaction.
- **`MIXCOL_INV_EN` undefined:**
  - The inverse logic is removed.
  - `Mode` is ignored; every transaction is forward.
  - The port remains for interface stability.

## Structure
- **Shared package `aes_pkg`:**
  - `GF_POLY` = 8'h1B.
  - The 128-bit state typedef.
  - The 32-bit column typedef.
  - The FSM state enum (IDLE/RUN/DONE).
  - Mode encodings `MIX_FWD`/`MIX_INV`.
- **Sub-module `gf_mix_column`:** combinational single-column transform with inputs column[31:0] and mode, and output column[31:0]. It is instantiated N times, and the write-back is muxed by `cnt`.

## Test plan
- **Forward, N=1:** `In_data`=d4bf5d30e0b452aeb84111f11e2798e5 → after 4 cycles, `Out_data`=046681e5e0cb199a48f8d37a2806264c.
- **Inverse, N=1:** `In_data`=046681e5e0cb199a48f8d37a2806264c → `Out_data`=d4bf5d30e0b452aeb84111f11e2798e5.
- **Forward, N=4:** `In_data`=db135345f20a225c01010101c6c6c6c6 → one cycle later, `Out_data`=8e4da1bc9fdc589d01010101c6c6c6c6.
- **Backpressure, N=2:**
  - Hold `Out_ready`=0 for 5 cycles after `Out_valid`. `Out_data` must stay stable and `In_ready`=0.
  - Then assert `Out_ready` together with `In_valid`. The new state must be accepted that same cycle.
- **Reset mid-RUN:** pulse `Rst_n` low during cycle 2 of 4 → `Out_valid`=0, `In_ready`=1, `Busy`=0 immediately, and no output appears for the aborted state.
- **Build without `MIXCOL_INV_EN`:** `Mode`=1 with d4bf5d30e0b452aeb84111f11e2798e5 → forward result 046681e5e0cb199a48f8d37a2806264c.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath types, constants and GF(2^8) helper
package aes_pkg;

    localparam logic [7:0] GF_POLY = 8'h1B;

    // Column c of the state sits at index [3-c], so column 0 occupies bits [127:96]
    typedef logic [3:0][31:0] aes_state_t;
    typedef logic [31:0]      aes_col_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mix_fsm_t;

    localparam logic MIX_FWD = 1'b0;
    localparam logic MIX_INV = 1'b1;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/gf_mix_column.sv
// rtl/gf_mix_column.sv - combinational MixColumns/InvMixColumns on one column (inverse under MIXCOL_INV_EN)
module gf_mix_column
    import aes_pkg::*;
(
    input  aes_col_t col_in,
    input  logic     mode,
    output aes_col_t col_out
);

    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x3 [4];
    aes_col_t   fwd;

    // Per-byte multiples by 1, 2 and 3 shared by every output row
    for (genvar r = 0; r < 4; r++) begin : g_fwd
        assign a[r]  = col_in[31-8*r -: 8];
        assign x2[r] = xtime(a[r]);
        assign x3[r] = x2[r] ^ a[r];
        assign fwd[31-8*r -: 8] = x2[r] ^ x3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end

`ifdef MIXCOL_INV_EN
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    aes_col_t   inv;

    // 9, B, D and E multiples are built from the same xtime chain
    for (genvar r = 0; r < 4; r++) begin : g_inv
        assign x4[r] = xtime(x2[r]);
        assign x8[r] = xtime(x4[r]);
        assign inv[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                                ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                                ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                                ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
    end

    assign col_out = (mode == MIX_INV) ? inv : fwd;
`else
    // Forward-only build: the mode pin is kept but has no effect
    logic unused_mode;
    assign unused_mode = mode;
    assign col_out     = fwd;
`endif

endmodule

// File: rtl/mix_col_engine.sv
// rtl/mix_col_engine.sv - handshaked in-place MixColumns engine, COLS_PER_CYCLE columns per clock (inverse under MIXCOL_INV_EN)
module mix_col_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         In_valid,
    output logic         In_ready,
    input  logic [127:0] In_data,
    input  logic         Mode,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic [127:0] Out_data,
    output logic         Busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_col_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int         GROUPS   = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_CNT = 2'(GROUPS - 1);
    localparam logic [1:0] N_COLS   = 2'(COLS_PER_CYCLE);

    mix_fsm_t   st_q;
    logic [1:0] cnt_q;
    aes_state_t data_q;
    logic       mode_q;
    logic       out_valid_q;
    logic       busy_q;

    logic [1:0] col_idx [COLS_PER_CYCLE];
    aes_col_t   col_old [COLS_PER_CYCLE];
    aes_col_t   col_new [COLS_PER_CYCLE];

    // One transform lane per column handled in a cycle; lane g works on column cnt*N+g
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign col_idx[g] = cnt_q * N_COLS + 2'(g);
        assign col_old[g] = data_q[2'd3 - col_idx[g]];

        gf_mix_column u_col (
            .col_in  (col_old[g]),
            .mode    (mode_q),
            .col_out (col_new[g])
        );
    end

    // Only combinational input-to-output path: acceptance overlaps the DONE cycle
    assign In_ready  = (st_q == IDLE) || ((st_q == DONE) && Out_ready);
    assign Out_valid = out_valid_q;
    assign Out_data  = data_q;
    assign Busy      = busy_q;

    // Transaction FSM with in-place column write-back
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            st_q        <= IDLE;
            cnt_q       <= 2'd0;
            data_q      <= '0;
            mode_q      <= MIX_FWD;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (In_valid) begin
                        data_q <= In_data;
                        mode_q <= Mode;
                        cnt_q  <= 2'd0;
                        busy_q <= 1'b1;
                        st_q   <= RUN;
                    end
                end
                RUN: begin
                    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                        data_q[2'd3 - col_idx[g]] <= col_new[g];
                    end
                    if (cnt_q == LAST_CNT) begin
                        cnt_q       <= 2'd0;
                        out_valid_q <= 1'b1;
                        st_q        <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    if (Out_ready) begin
                        out_valid_q <= 1'b0;
                        if (In_valid) begin
                            data_q <= In_data;
                            mode_q <= Mode;
                            cnt_q  <= 2'd0;
                            st_q   <= RUN;
                        end else begin
                            busy_q <= 1'b0;
                            st_q   <= IDLE;
                        end
                    end
                end
                default: begin
                    st_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_col_engine.sv
// tb/tb_mix_col_engine.sv - directed self-checking bench for mix_col_engine at N=1, 2 and 4
module tb_mix_col_engine;

    localparam logic [127:0] VEC_A = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] VEC_B = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] VEC_C = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] VEC_D = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

    logic clk;
    logic rst_n;

    logic         iv1, ir1, m1, ov1, or1, b1;
    logic [127:0] id1, od1;
    logic         iv2, ir2, m2, ov2, or2, b2;
    logic [127:0] id2, od2;
    logic         iv4, ir4, m4, ov4, or4, b4;
    logic [127:0] id4, od4;

    int tests;
    int fails;

    mix_col_engine #(.COLS_PER_CYCLE(1)) u_dut1 (
        .Clk(clk), .Rst_n(rst_n), .In_valid(iv1), .In_ready(ir1), .In_data(id1), .Mode(m1),
        .Out_valid(ov1), .Out_ready(or1), .Out_data(od1), .Busy(b1)
    );

    mix_col_engine #(.COLS_PER_CYCLE(2)) u_dut2 (
        .Clk(clk), .Rst_n(rst_n), .In_valid(iv2), .In_ready(ir2), .In_data(id2), .Mode(m2),
        .Out_valid(ov2), .Out_ready(or2), .Out_data(od2), .Busy(b2)
    );

    mix_col_engine #(.COLS_PER_CYCLE(4)) u_dut4 (
        .Clk(clk), .Rst_n(rst_n), .In_valid(iv4), .In_ready(ir4), .In_data(id4), .Mode(m4),
        .Out_valid(ov4), .Out_ready(or4), .Out_data(od4), .Busy(b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if ({ir1, ov1, b1} !== 3'b100) begin fails++; $display("FAIL reset_flags_n1: got %b expected 100", {ir1, ov1, b1}); end
        tests++; if (od1 !== 128'h0) begin fails++; $display("FAIL reset_data_n1: got %h expected 0", od1); end
        tests++; if ({ir2, ov2, b2, ir4, ov4, b4} !== 6'b100100) begin fails++; $display("FAIL reset_flags_n2n4: got %b expected 100100", {ir2, ov2, b2, ir4, ov4, b4}); end
        tests++; if ((od2 | od4) !== 128'h0) begin fails++; $display("FAIL reset_data_n2n4: got %h/%h expected 0", od2, od4); end
        rst_n = 1'b1;
        @(negedge clk);
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
        tests++; if ({ir1, ov1, b1} !== 3'b100) begin fails++; $display("FAIL stray_out_ready: got %b expected 100", {ir1, ov1, b1}); end
    endtask

    task automatic test_forward_n1();
        int lat;
        @(negedge clk);
        iv1 = 1'b1; id1 = VEC_A; m1 = 1'b0;
        tests++; if (ir1 !== 1'b1) begin fails++; $display("FAIL fwd1_in_ready: got %b expected 1", ir1); end
        @(negedge clk);
        iv1 = 1'b0; m1 = 1'b1; id1 = '0;
        lat = 0;
        while (ov1 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        tests++; if (lat !== 4) begin fails++; $display("FAIL fwd1_latency: got %0d expected 4", lat); end
        tests++; if (od1 !== VEC_B) begin fails++; $display("FAIL fwd1_data: got %h expected %h", od1, VEC_B); end
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0; m1 = 1'b0;
        tests++; if ({ov1, b1, ir1} !== 3'b001) begin fails++; $display("FAIL fwd1_drain: got %b expected 001", {ov1, b1, ir1}); end
    endtask

    task automatic test_mode_n1();
        int lat;
        @(negedge clk);
        iv1 = 1'b1; m1 = 1'b1;
`ifdef MIXCOL_INV_EN
        id1 = VEC_B;
`else
        id1 = VEC_A;
`endif
        @(negedge clk);
        iv1 = 1'b0; m1 = 1'b0;
        lat = 0;
        while (ov1 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        tests++; if (lat !== 4) begin fails++; $display("FAIL mode1_latency: got %0d expected 4", lat); end
`ifdef MIXCOL_INV_EN
        tests++; if (od1 !== VEC_A) begin fails++; $display("FAIL inv1_data: got %h expected %h", od1, VEC_A); end
`else
        tests++; if (od1 !== VEC_B) begin fails++; $display("FAIL mode_ignored_data: got %h expected %h", od1, VEC_B); end
`endif
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
    endtask

    task automatic test_forward_n4();
        int lat;
        @(negedge clk);
        iv4 = 1'b1; id4 = VEC_C; m4 = 1'b0;
        @(negedge clk);
        iv4 = 1'b0;
        lat = 0;
        while (ov4 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        tests++; if (lat !== 1) begin fails++; $display("FAIL fwd4_latency: got %0d expected 1", lat); end
        tests++; if (od4 !== VEC_D) begin fails++; $display("FAIL fwd4_data: got %h expected %h", od4, VEC_D); end
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        tests++; if ({ov4, b4} !== 2'b00) begin fails++; $display("FAIL fwd4_drain: got %b expected 00", {ov4, b4}); end
    endtask

    task automatic test_backpressure_n2();
        int lat;
        logic [127:0] held;
        @(negedge clk);
        iv2 = 1'b1; id2 = VEC_A; m2 = 1'b0;
        @(negedge clk);
        iv2 = 1'b0;
        lat = 0;
        while (ov2 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        tests++; if (lat !== 2) begin fails++; $display("FAIL bp_latency: got %0d expected 2", lat); end
        tests++; if (od2 !== VEC_B) begin fails++; $display("FAIL bp_data: got %h expected %h", od2, VEC_B); end
        held = od2;
        iv2 = 1'b1; id2 = VEC_C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({ov2, ir2} !== 2'b10 || od2 !== VEC_B) begin
                fails++; $display("FAIL bp_hold_%0d: got ov=%b ir=%b data=%h expected ov=1 ir=0 data=%h", i, ov2, ir2, od2, VEC_B);
            end
        end
        tests++; if (od2 !== held) begin fails++; $display("FAIL bp_stable: got %h expected %h", od2, held); end
        or2 = 1'b1;
        #1;
        tests++; if (ir2 !== 1'b1) begin fails++; $display("FAIL bp_in_ready_comb: got %b expected 1", ir2); end
        @(negedge clk);
        iv2 = 1'b0; or2 = 1'b0;
        tests++; if ({ov2, b2, ir2} !== 3'b010) begin fails++; $display("FAIL bp_reaccept: got %b expected 010", {ov2, b2, ir2}); end
        lat = 0;
        while (ov2 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        tests++; if (lat !== 2) begin fails++; $display("FAIL bp2_latency: got %0d expected 2", lat); end
        tests++; if (od2 !== VEC_D) begin fails++; $display("FAIL bp2_data: got %h expected %h", od2, VEC_D); end
        or2 = 1'b1;
        @(negedge clk);
        or2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nvalid;
        @(negedge clk);
        iv1 = 1'b1; or1 = 1'b1; id1 = VEC_C; m1 = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            tests++;
            if (ov1 !== ((i % 5) == 4)) begin
                fails++; $display("FAIL b2b_valid_%0d: got %b expected %b", i, ov1, (i % 5) == 4);
            end
            if (ov1 === 1'b1) begin
                nvalid++;
                tests++; if (od1 !== VEC_D) begin fails++; $display("FAIL b2b_data_%0d: got %h expected %h", i, od1, VEC_D); end
            end
        end
        iv1 = 1'b0;
        @(negedge clk);
        or1 = 1'b0;
        tests++; if (nvalid !== 3) begin fails++; $display("FAIL b2b_count: got %0d expected 3", nvalid); end
        tests++; if ({ov1, b1} !== 2'b00) begin fails++; $display("FAIL b2b_idle: got %b expected 00", {ov1, b1}); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        iv1 = 1'b1; id1 = VEC_A; m1 = 1'b0;
        @(negedge clk);
        iv1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if ({ov1, ir1, b1} !== 3'b010) begin fails++; $display("FAIL rst_mid_flags: got %b expected 010", {ov1, ir1, b1}); end
        tests++; if (od1 !== 128'h0) begin fails++; $display("FAIL rst_mid_data: got %h expected 0", od1); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov1 === 1'b1 || b1 === 1'b1) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rst_mid_no_output: got %0d active cycles expected 0", seen); end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0;
        iv1 = 1'b0; id1 = '0; m1 = 1'b0; or1 = 1'b0;
        iv2 = 1'b0; id2 = '0; m2 = 1'b0; or2 = 1'b0;
        iv4 = 1'b0; id4 = '0; m4 = 1'b0; or4 = 1'b0;
        test_reset();
        test_forward_n1();
        test_mode_n1();
        test_forward_n4();
        test_backpressure_n2();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
